// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the ID/EX operand stage and its forwarding muxes.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Encoding 2'b11 is not named; it behaves as BSEL_REG.
  typedef enum logic [1:0] {
    BSEL_REG   = 2'b00,
    BSEL_IMM   = 2'b01,
    BSEL_SHAMT = 2'b10
  } bsel_t;

  // Encoding 2'b11 is not named; it behaves as EXT_ZERO.
  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } extop_t;

  // Everything the stage latches from decode; the immediate is stored already extended.
  typedef struct packed {
    logic [3:0] aluop;
    word_t      rdat1;
    word_t      rdat2;
    regbits_t   rs;
    regbits_t   rt;
    regbits_t   wsel;
    logic       regwen;
    word_t      imm;
    logic [4:0] shamt;
    logic [1:0] bsel;
  } idex_t;

  function automatic word_t ext_imm(input logic [15:0] imm16, input logic [1:0] extop);
    case (extop)
      EXT_SIGN: return {{16{imm16[15]}}, imm16};
      EXT_LUI:  return {imm16, 16'h0000};
      default:  return {16'h0000, imm16};
    endcase
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand result forwarding: EX/MEM beats MEM/WB, register 0 never forwards.
// With ID_EX_FORWARD_EN undefined the mux collapses to a wire from the latched data.
module fwd_mux #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [WORD_W-1:0] dat,
  input  logic              p1_regwen,
  input  logic [REG_W-1:0]  p1_wsel,
  input  logic [WORD_W-1:0] p1_dat,
  input  logic              p2_regwen,
  input  logic [REG_W-1:0]  p2_wsel,
  input  logic [WORD_W-1:0] p2_dat,
  output logic [WORD_W-1:0] fwd
);

`ifdef ID_EX_FORWARD_EN
  // Pick the youngest in-flight producer of idx, else the register file value.
  always_comb begin
    fwd = dat;
    if (p1_regwen && (p1_wsel == idx) && (idx != '0))
      fwd = p1_dat;
    else if (p2_regwen && (p2_wsel == idx) && (idx != '0))
      fwd = p2_dat;
  end
`else
  logic unused_prod;
  assign unused_prod = ^{idx, p1_regwen, p1_wsel, p1_dat, p2_regwen, p2_wsel, p2_dat};
  assign fwd = dat;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary register feeding the ALU: handshake capture, immediate/shamt
// selection for PortB, and EX/MEM + MEM/WB forwarding (ID_EX_FORWARD_EN).
module id_ex_operand_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::WORD_W,
  parameter int REG_W  = cpu_types_pkg::REG_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        id_aluop,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic              id_regwen,
  input  logic [15:0]       id_imm16,
  input  logic [4:0]        id_shamt,
  input  logic [1:0]        id_bsel,
  input  logic [1:0]        id_extop,
  input  logic              ex_ready,
  input  logic              exmem_regwen,
  input  logic [REG_W-1:0]  exmem_wsel,
  input  logic [WORD_W-1:0] exmem_result,
  input  logic              memwb_regwen,
  input  logic [REG_W-1:0]  memwb_wsel,
  input  logic [WORD_W-1:0] memwb_wdat,
  output logic              ex_valid,
  output logic [3:0]        ex_aluop,
  output logic [WORD_W-1:0] ex_porta,
  output logic [WORD_W-1:0] ex_portb,
  output logic [WORD_W-1:0] ex_storedat,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwen
);

  idex_t             lat;
  logic              load;
  logic [WORD_W-1:0] fwd_a;
  logic [WORD_W-1:0] fwd_b;

  // A slot is free when empty or when execute takes the current occupant.
  assign in_ready = !ex_valid || ex_ready;
  assign load     = in_valid && in_ready;

  // Stage register: reset > flush > load > drain; otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid <= 1'b0;
      lat      <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid   <= 1'b1;
      lat.aluop  <= id_aluop;
      lat.rdat1  <= id_rdat1;
      lat.rdat2  <= id_rdat2;
      lat.rs     <= id_rs;
      lat.rt     <= id_rt;
      lat.wsel   <= id_wsel;
      lat.regwen <= id_regwen;
      lat.imm    <= ext_imm(id_imm16, id_extop);
      lat.shamt  <= id_shamt;
      lat.bsel   <= id_bsel;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_a (
    .idx(lat.rs), .dat(lat.rdat1),
    .p1_regwen(exmem_regwen), .p1_wsel(exmem_wsel), .p1_dat(exmem_result),
    .p2_regwen(memwb_regwen), .p2_wsel(memwb_wsel), .p2_dat(memwb_wdat),
    .fwd(fwd_a)
  );

  fwd_mux #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_b (
    .idx(lat.rt), .dat(lat.rdat2),
    .p1_regwen(exmem_regwen), .p1_wsel(exmem_wsel), .p1_dat(exmem_result),
    .p2_regwen(memwb_regwen), .p2_wsel(memwb_wsel), .p2_dat(memwb_wdat),
    .fwd(fwd_b)
  );

  // PortB source select; the unnamed 2'b11 encoding falls back to the register.
  always_comb begin
    ex_portb = fwd_b;
    case (lat.bsel)
      BSEL_IMM:   ex_portb = lat.imm;
      BSEL_SHAMT: ex_portb = {{(WORD_W-5){1'b0}}, lat.shamt};
      default:    ex_portb = fwd_b;
    endcase
  end

  assign ex_aluop    = lat.aluop;
  assign ex_porta    = fwd_a;
  assign ex_storedat = fwd_b;
  assign ex_wsel     = lat.wsel;
  assign ex_regwen   = lat.regwen && ex_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed + randomized bench for id_ex_operand_stage against a behavioural model.
module tb_id_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RST, flush, in_valid, in_ready, ex_ready;
  logic [3:0]  id_aluop;
  logic [31:0] id_rdat1, id_rdat2;
  logic [4:0]  id_rs, id_rt, id_wsel, id_shamt;
  logic        id_regwen;
  logic [15:0] id_imm16;
  logic [1:0]  id_bsel, id_extop;
  logic        exmem_regwen, memwb_regwen;
  logic [4:0]  exmem_wsel, memwb_wsel;
  logic [31:0] exmem_result, memwb_wdat;
  logic        ex_valid, ex_regwen;
  logic [3:0]  ex_aluop;
  logic [31:0] ex_porta, ex_portb, ex_storedat;
  logic [4:0]  ex_wsel;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_operand_stage dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .id_aluop(id_aluop), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel), .id_regwen(id_regwen),
    .id_imm16(id_imm16), .id_shamt(id_shamt), .id_bsel(id_bsel), .id_extop(id_extop),
    .ex_ready(ex_ready),
    .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
    .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_porta(ex_porta), .ex_portb(ex_portb),
    .ex_storedat(ex_storedat), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen)
  );

  always #5 CLK = ~CLK;

  // Reference model: the instruction currently held for execute, as decoded values.
  typedef struct {
    bit          valid;
    int unsigned aluop, rs, rt, wsel, bsel, shamt;
    bit          regwen;
    logic [31:0] a, b, imm;
  } instr_t;

  instr_t held, nxt;

  function automatic logic [31:0] imm_value(logic [15:0] imm, logic [1:0] ext);
    if (ext == 2'd1) return 32'($signed(imm));
    if (ext == 2'd2) return 32'(imm) * 32'h10000;
    return 32'(imm);
  endfunction

  function automatic logic [31:0] operand(int unsigned idx, logic [31:0] regval);
`ifdef ID_EX_FORWARD_EN
    if (idx != 0 && exmem_regwen && int'(exmem_wsel) == idx) return exmem_result;
    if (idx != 0 && memwb_regwen && int'(memwb_wsel) == idx) return memwb_wdat;
`endif
    return regval;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] pb;
    pb = operand(held.rt, held.b);
    if (held.bsel == 1) pb = held.imm;
    else if (held.bsel == 2) pb = 32'(held.shamt);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!held.valid || ex_ready));
    chk({tag, ".valid"},    32'(ex_valid), 32'(held.valid));
    chk({tag, ".aluop"},    32'(ex_aluop), held.aluop);
    chk({tag, ".porta"},    ex_porta, operand(held.rs, held.a));
    chk({tag, ".portb"},    ex_portb, pb);
    chk({tag, ".storedat"}, ex_storedat, operand(held.rt, held.b));
    chk({tag, ".wsel"},     32'(ex_wsel), held.wsel);
    chk({tag, ".regwen"},   32'(ex_regwen), 32'(held.regwen && held.valid));
  endtask

  // Advance one clock; model decides what the stage holds after the edge.
  task automatic tick();
    nxt = held;
    if (RST) begin
      nxt = '{default: 0};
    end else if (flush) begin
      nxt.valid = 0;
    end else if (in_valid && (!held.valid || ex_ready)) begin
      nxt.valid = 1;     nxt.aluop = id_aluop;  nxt.a = id_rdat1;  nxt.b = id_rdat2;
      nxt.rs = id_rs;    nxt.rt = id_rt;        nxt.wsel = id_wsel; nxt.regwen = id_regwen;
      nxt.imm = imm_value(id_imm16, id_extop); nxt.shamt = id_shamt; nxt.bsel = id_bsel;
    end else if (ex_ready) begin
      nxt.valid = 0;
    end
    @(posedge CLK);
    #1;
    held = nxt;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ws,
                        input logic rw, input logic [15:0] imm, input logic [4:0] sh,
                        input logic [1:0] bs, input logic [1:0] ext);
    id_aluop = op; id_rdat1 = r1; id_rdat2 = r2; id_rs = rs; id_rt = rt; id_wsel = ws;
    id_regwen = rw; id_imm16 = imm; id_shamt = sh; id_bsel = bs; id_extop = ext;
  endtask

  logic [31:0] exp_fwd;

  initial begin
    held = '{default: 0};
    RST = 1; flush = 0; in_valid = 0; ex_ready = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_regwen = 0; exmem_wsel = 0; exmem_result = 0;
    memwb_regwen = 0; memwb_wsel = 0; memwb_wdat = 0;

    // Reset held two cycles, then released with nothing arriving.
    tick(); tick();
    RST = 0;
    tick();
    chk("rst.valid", 32'(ex_valid), 0);
    chk("rst.aluop", 32'(ex_aluop), 0);
    chk("rst.porta", ex_porta, 0);
    chk("rst.portb", ex_portb, 0);
    check_all("rst");

    // ADD with register operands, then drain.
    ex_ready = 1; in_valid = 1;
    set_id(4'd2, 32'd5, 32'd7, 5'd1, 5'd2, 5'd8, 1, 16'h0, 5'd0, 2'd0, 2'd0);
    tick();
    in_valid = 0; #1;
    chk("add.porta", ex_porta, 32'd5);
    chk("add.portb", ex_portb, 32'd7);
    chk("add.valid", 32'(ex_valid), 1);
    check_all("add");
    tick();
    chk("drain.valid", 32'(ex_valid), 0);

    // Immediate forms back to back.
    in_valid = 1;
    set_id(4'd2, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1, 16'hFFFC, 5'd0, 2'd1, 2'd1);
    tick();
    chk("imm.sign", ex_portb, 32'hFFFF_FFFC);
    set_id(4'd5, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1, 16'h1234, 5'd0, 2'd1, 2'd2);
    tick();
    chk("imm.lui", ex_portb, 32'h1234_0000);
    set_id(4'd0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1, 16'hFFFF, 5'd4, 2'd2, 2'd1);
    tick();
    chk("imm.shamt", ex_portb, 32'd4);
    check_all("imm");

    // Forwarding priority on operand A, then hold the instruction.
    set_id(4'd2, 32'd1, 32'd9, 5'd3, 5'd4, 5'd6, 1, 16'h0, 5'd0, 2'd0, 2'd0);
    tick();
    in_valid = 0; ex_ready = 0;
    exmem_regwen = 1; exmem_wsel = 3; exmem_result = 32'hAA;
    memwb_regwen = 1; memwb_wsel = 3; memwb_wdat = 32'hBB;
    #1;
`ifdef ID_EX_FORWARD_EN
    exp_fwd = 32'hAA;
`else
    exp_fwd = 32'h1;
`endif
    chk("fwd.exmem", ex_porta, exp_fwd);
    check_all("fwd1");
    exmem_regwen = 0; #1;
`ifdef ID_EX_FORWARD_EN
    exp_fwd = 32'hBB;
`else
    exp_fwd = 32'h1;
`endif
    chk("fwd.memwb", ex_porta, exp_fwd);
    check_all("fwd2");
    ex_ready = 1; in_valid = 1;
    exmem_regwen = 1; exmem_wsel = 0; memwb_wsel = 0;
    set_id(4'd2, 32'h77, 32'h3, 5'd0, 5'd0, 5'd6, 1, 16'h0, 5'd0, 2'd0, 2'd0);
    tick();
    in_valid = 0; ex_ready = 0; #1;
    chk("fwd.r0", ex_porta, 32'h77);
    check_all("fwd3");

    // Stall: new instructions offered while execute is blocked.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      set_id(4'd3, 32'h100 + i, 32'h200 + i, 5'd1, 5'd2, 5'd9, 1, 16'h0, 5'd0, 2'd0, 2'd0);
      #1;
      chk("stall.in_ready", 32'(in_ready), 0);
      tick();
      chk("stall.porta", ex_porta, 32'h77);
      chk("stall.valid", 32'(ex_valid), 1);
    end
    ex_ready = 1;
    set_id(4'd4, 32'h555, 32'h666, 5'd0, 5'd0, 5'd10, 1, 16'h0, 5'd0, 2'd0, 2'd0);
    #1;
    chk("unstall.in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0; #1;
    chk("unstall.porta", ex_porta, 32'h555);
    check_all("unstall");

    // Flush beats a simultaneous load.
    flush = 1; in_valid = 1;
    tick();
    flush = 0; in_valid = 0; #1;
    chk("flush.valid", 32'(ex_valid), 0);
    chk("flush.regwen", 32'(ex_regwen), 0);
    check_all("flush");

    // Reset in the middle of a stall.
    in_valid = 1;
    set_id(4'd2, 32'h99, 32'h98, 5'd0, 5'd0, 5'd5, 1, 16'h0, 5'd0, 2'd0, 2'd0);
    tick();
    in_valid = 0; ex_ready = 0;
    tick();
    chk("stallrst.pre", 32'(ex_valid), 1);
    RST = 1;
    tick();
    RST = 0; #1;
    chk("stallrst.valid", 32'(ex_valid), 0);
    chk("stallrst.porta", ex_porta, 0);
    check_all("stallrst");

    // Randomized traffic with small register indices to provoke forwarding hits.
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = $urandom_range(0, 1);
      ex_ready = ($urandom_range(0, 3) != 0);
      set_id(4'($urandom_range(0, 9)), $urandom, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), 1'($urandom), 16'($urandom),
             5'($urandom), 2'($urandom), 2'($urandom));
      exmem_regwen = 1'($urandom); exmem_wsel = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwen = 1'($urandom); memwb_wsel = 5'($urandom_range(0, 3)); memwb_wdat = $urandom;
      #1;
      check_all("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
